// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with pc, memory drive and 2-entry decode buffer
//
// Purpose: holds the program counter, reads the combinational instruction
// memory at pc, and hands {instruction, pc} to decode through a 2-entry FIFO
// with a valid/ready handshake. Supports redirect, level-sensitive halt and a
// sticky out-of-range fault stop.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   redirect_i          load redirect_pc_i (word aligned) into pc, flush buffer
//   redirect_pc_i       redirect target, bits [1:0] ignored
//   halt_i              stop fetching while high
//   mem_addr_o          memory address, always equals pc
//   mem_sel_o           memory select, constant read path
//   mem_we_o            memory write enable, constant 0
//   mem_rdata_i         instruction word for mem_addr_o, same cycle
//   instr_o, pc_o       buffer head instruction and its pc
//   instr_valid_o       buffer head valid
//   instr_ready_i       decode accepts head
//   busy_o              1 while fetching is allowed (FETCH state)
//   fault_o             sticky, pc left the memory range
module fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_sel_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  busy_o,
  output logic                  fault_o
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [DATA_WIDTH-1:0] PC_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic                  head_q, head_d;
  logic [DATA_WIDTH-1:0] buf_instr_q [2];
  logic [DATA_WIDTH-1:0] buf_pc_q    [2];

  logic pop;
  logic push;
  logic tail;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign pop  = (count_q != 2'd0) && instr_ready_i;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push = !redirect_i && (state_q == ST_FETCH) && !halt_i &&
                (pc_q < PC_LIMIT) && ((count_q != 2'd2) || pop);

  // Tail slot is head+count mod 2; with count==2 that is the slot the pop frees.
  assign tail = head_q ^ count_q[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    if (redirect_i) begin
      // Flush discards even a head offered this cycle: it is not transferred.
      state_d = ST_FETCH;
      pc_d    = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (halt_i) begin
            state_d = ST_HALT;
          end else if (pc_q >= PC_LIMIT) begin
            state_d = ST_FAULT;
          end
        end
        ST_HALT: begin
          if (!halt_i) begin
            state_d = ST_FETCH;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_FAULT;
      endcase
      if (push) begin
        pc_d = pc_q + PC_STEP;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      state_q        <= ST_FETCH;
      count_q        <= 2'd0;
      head_q         <= 1'b0;
      buf_instr_q[0] <= '0;
      buf_instr_q[1] <= '0;
      buf_pc_q[0]    <= '0;
      buf_pc_q[1]    <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      if (push) begin
        buf_instr_q[tail] <= mem_rdata_i;
        buf_pc_q[tail]    <= pc_q;
      end
    end
  end

  assign mem_addr_o    = pc_q;
  assign mem_sel_o     = 1'b1;
  assign mem_we_o      = 1'b0;
  assign instr_o       = buf_instr_q[head_q];
  assign pc_o          = buf_pc_q[head_q];
  assign instr_valid_o = (count_q != 2'd0);
  assign busy_o        = (state_q == ST_FETCH);
  // FAULT is entered only with the fault flag and left only by redirect/reset,
  // so the flag is exactly the state.
  assign fault_o       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

  localparam int          DEPTH = 64;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic [31:0] mem_addr_o;
  logic        mem_sel_o;
  logic        mem_we_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        busy_o;
  logic        fault_o;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .mem_addr_o    (mem_addr_o),
    .mem_sel_o     (mem_sel_o),
    .mem_we_o      (mem_we_o),
    .mem_rdata_i   (mem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .busy_o        (busy_o),
    .fault_o       (fault_o)
  );

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // Combinational instruction memory; out-of-range reads return a poison word.
  assign mem_rdata_i = (mem_addr_o < LIMIT) ? word_at(mem_addr_o) : 32'hBAD0_BAD0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: pc, halted/faulted flags and a queue of {instr, pc}.
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_faulted;
  logic [63:0] m_q[$];

  task automatic model_reset();
    m_pc      = 32'h0;
    m_halted  = 1'b0;
    m_faulted = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step(input bit rd, input logic [31:0] rpc, input bit h, input bit rdy);
    int sz;
    bit pop;
    sz  = m_q.size();
    pop = (sz > 0) && rdy;
    if (rd) begin
      m_q.delete();
      m_pc      = rpc & 32'hFFFF_FFFC;
      m_halted  = 1'b0;
      m_faulted = 1'b0;
      return;
    end
    if (pop) void'(m_q.pop_front());
    if (m_halted) begin
      if (!h) m_halted = 1'b0;
    end else if (!m_faulted) begin
      if (h) m_halted = 1'b1;
      else if (m_pc >= LIMIT) m_faulted = 1'b1;
      else if (sz < 2 || pop) begin
        m_q.push_back({word_at(m_pc), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] head;
    check_eq("valid", 32'(instr_valid_o), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      head = m_q[0];
      check_eq("instr", instr_o, head[63:32]);
      check_eq("pc_o", pc_o, head[31:0]);
    end
    check_eq("mem_addr", mem_addr_o, m_pc);
    check_eq("busy", 32'(busy_o), 32'(!m_halted && !m_faulted));
    check_eq("fault", 32'(fault_o), 32'(m_faulted));
    check_eq("mem_sel", 32'(mem_sel_o), 32'd1);
    check_eq("mem_we", 32'(mem_we_o), 32'd0);
  endtask

  // Called just after a falling edge: drive, advance model, sample at next falling edge.
  task automatic run_cycle(input bit rd, input logic [31:0] rpc, input bit h, input bit rdy);
    redirect_i    = rd;
    redirect_pc_i = rpc;
    halt_i        = h;
    instr_ready_i = rdy;
    model_step(rd, rpc, h, rdy);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [31:0] rpc;
    bit          rd;
    bit          h;
    bit          rdy;

    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    halt_i        = 1'b0;
    instr_ready_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);

    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_instr", instr_o, 32'd0);
    check_eq("rst_pc_o", pc_o, 32'd0);
    check_eq("rst_addr", mem_addr_o, 32'd0);
    check_eq("rst_sel", 32'(mem_sel_o), 32'd1);
    check_eq("rst_we", 32'(mem_we_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd1);
    check_eq("rst_fault", 32'(fault_o), 32'd0);

    rst_n = 1'b1;
    run_cycle(0, 32'h0, 0, 1);
    check_eq("first_valid", 32'(instr_valid_o), 32'd1);

    // Backpressure: buffer fills, pc stalls at 8, head holds.
    repeat (5) run_cycle(0, 32'h0, 0, 0);
    check_eq("stall_addr", mem_addr_o, 32'h8);
    check_eq("stall_instr", instr_o, 32'h1000_0000);
    repeat (8) run_cycle(0, 32'h0, 0, 1);

    // Redirect to an unaligned target while the buffer is full.
    repeat (2) run_cycle(0, 32'h0, 0, 0);
    run_cycle(1, 32'h0000_0023, 0, 1);
    check_eq("redir_valid", 32'(instr_valid_o), 32'd0);
    check_eq("redir_addr", mem_addr_o, 32'h20);
    run_cycle(0, 32'h0, 0, 1);
    check_eq("redir_pc_o", pc_o, 32'h20);
    check_eq("redir_instr", instr_o, 32'h1000_0008);

    // Halt drains the buffer, then resumes at the held pc.
    repeat (3) run_cycle(0, 32'h0, 1, 1);
    check_eq("halt_busy", 32'(busy_o), 32'd0);
    check_eq("halt_valid", 32'(instr_valid_o), 32'd0);
    repeat (4) run_cycle(0, 32'h0, 0, 1);

    // Run off the end of memory.
    run_cycle(1, 32'h0000_00F8, 0, 1);
    repeat (5) run_cycle(0, 32'h0, 0, 1);
    check_eq("range_fault", 32'(fault_o), 32'd1);
    check_eq("range_addr", mem_addr_o, 32'h100);
    run_cycle(1, 32'h0, 0, 1);
    check_eq("clear_fault", 32'(fault_o), 32'd0);
    run_cycle(0, 32'h0, 0, 1);
    check_eq("refetch_instr", instr_o, 32'h1000_0000);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rd  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) rpc = $urandom;
      else rpc = 32'($urandom_range(0, 32'h120));
      h   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      run_cycle(rd, rpc, h, rdy);
    end

    // Asynchronous reset while faulted with a valid head.
    run_cycle(1, 32'h0000_00FC, 0, 0);
    repeat (2) run_cycle(0, 32'h0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("arst_fault", 32'(fault_o), 32'd0);
    check_eq("arst_addr", mem_addr_o, 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    run_cycle(0, 32'h0, 0, 1);
    check_eq("arst_restart_pc", pc_o, 32'd0);
    repeat (3) run_cycle(0, 32'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
